mem_stage_sram: RTL and testbench
=================================

MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 Parameter: WAIT_CYCLES, 2, cycles each 16-bit SRAM phase is held (1..15).
REQ-002 Parameter: BASE_ADDR, 1024, byte address mapped to SRAM word 0.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 wb_en_in, mem_r_en_in, mem_w_en_in  input  1 each  control from EXE register.
REQ-006 alu_res_in  input  32  byte address (loads/stores) or ALU result.
REQ-007 val_rm_in  input  32  store data.
REQ-008 dest_in  input  4  destination register index.
REQ-009 wb_en, mem_r_en  output  1 each  pass-through of wb_en_in, mem_r_en_in.
REQ-010 alu_res  output  32  pass-through of alu_res_in.
REQ-011 dest  output  4  pass-through of dest_in.
REQ-012 mem_data  output  32  registered load result.
REQ-013 ready  output  1  0 = freeze pipeline (PC, IF/ID/EXE registers hold); 1 = advance.
REQ-014 sram_addr  output  18  SRAM halfword address.
REQ-015 sram_dq_out  output  16  write data; sram_dq_oe  output  1  drive enable.
REQ-016 sram_dq_in  input  16  read data from SRAM.
REQ-017 sram_we_n  output  1  SRAM write strobe, active-low.

Function
REQ-018 The pass-through outputs SHALL be combinational copies of their inputs, unaffected by FSM state.
REQ-019 The FSM SHALL have states IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE.
REQ-020 In IDLE, mem_w_en_in=1 SHALL move to WR_LO; otherwise, mem_r_en_in=1 SHALL move to RD_LO (write has priority if both are set); otherwise, it SHALL stay in IDLE.
REQ-021 ready SHALL be combinational: 0 in IDLE with a request pending and in all RD_*/WR_* states; 1 in DONE and in IDLE with no request.
REQ-022 Each RD_*/WR_* state SHALL last exactly WAIT_CYCLES cycles, timed by a wait counter cleared on every state entry.
REQ-023 Transitions: RD_LO->RD_HI->DONE and WR_LO->WR_HI->DONE; DONE SHALL last one cycle, then return to IDLE unconditionally.
REQ-024 ready SHALL therefore be low for exactly 1+2*WAIT_CYCLES consecutive cycles per access.
REQ-025 The word index SHALL be (alu_res_in - BASE_ADDR) mod 2^32, bits [18:2]; address bits [1:0] are ignored.
REQ-026 sram_addr SHALL be {word index, 0} in *_LO states and {word index, 1} in *_HI states; it SHALL be 0 otherwise.
REQ-027 In WR_LO, sram_dq_out SHALL be val_rm_in[15:0]; in WR_HI, it SHALL be val_rm_in[31:16].
REQ-028 In WR_* states, sram_we_n=0 and sram_dq_oe=1; in all other states, sram_we_n=1, sram_dq_oe=0 and sram_dq_out=0.
REQ-029 mem_data[15:0] SHALL capture sram_dq_in on the last cycle of RD_LO.
REQ-030 mem_data[31:16] SHALL capture sram_dq_in on the last cycle of RD_HI.
REQ-031 mem_data SHALL be held at all other times, including across writes.
REQ-032 Inputs are stable while ready=0 (upstream frozen); the block SHALL NOT re-sample request type mid-access.
REQ-033 A request still asserted in DONE SHALL NOT start a new access in DONE; the next IDLE cycle SHALL evaluate the then-current inputs.

Reset
REQ-034 rst=1 SHALL force IDLE, clear the wait counter, and set mem_data=0, sram_we_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, with immediate effect.
REQ-035 Reset asserted mid-access SHALL abort it; a partial write leaves SRAM contents undefined, and no partial read SHALL update mem_data beyond halves already captured before reset (which are then cleared).
REQ-036 After reset release with no request pending, ready SHALL be 1.

Verification
REQ-037 Store, WAIT_CYCLES=2, alu_res_in=1028, val_rm_in=0xDEADBEEF -> ready low 5 cycles; addr 2 with dq 0xBEEF, then addr 3 with dq 0xDEAD, we_n low 4 cycles.
REQ-038 Load from 1028 after REQ-037 with SRAM model returning stored data -> mem_data=0xDEADBEEF in DONE cycle, ready=1 that cycle.
REQ-039 Both mem_r_en_in and mem_w_en_in=1 -> write sequence executed, mem_data unchanged.
REQ-040 Back-to-back loads at 1024 and 1032 -> two separate 5-cycle ready-low windows separated by one DONE cycle; mem_data updates after each.
REQ-041 rst asserted in second cycle of RD_HI -> same cycle IDLE, mem_data=0, we_n=1; ready=1 after release.
REQ-042 No request, wb_en_in=1, dest_in=7, alu_res_in=0x55 -> ready=1 constantly, outputs mirror inputs, sram_we_n=1.

Source files
------------

// File: rtl/mem_stage_sram.sv
// Memory stage of the pipeline, backed by a 16-bit wide external SRAM.
// A 32-bit load or store becomes two halfword phases (low half, then high
// half). Each phase holds its address/data for WAIT_CYCLES cycles. While an
// access is in flight, ready is low and the upstream pipeline is frozen.
module mem_stage_sram #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        wb_en_in,
    input  logic        mem_r_en_in,
    input  logic        mem_w_en_in,
    input  logic [31:0] alu_res_in,
    input  logic [31:0] val_rm_in,
    input  logic [3:0]  dest_in,

    output logic        wb_en,
    output logic        mem_r_en,
    output logic [31:0] alu_res,
    output logic [3:0]  dest,
    output logic [31:0] mem_data,
    output logic        ready,

    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    // Final value of the wait counter within a phase.
    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  wait_cnt;
    logic        wait_done;
    logic        in_access;
    logic [16:0] word_idx;

    // Only bits [18:2] of (alu_res_in - BASE_ADDR) matter. They are formed
    // from the upper slices directly, with the borrow out of bits [1:0]
    // folded in, so the result is exact without a full 32-bit subtract.
    assign word_idx = alu_res_in[18:2] - BASE_ADDR[18:2]
                    - 17'(alu_res_in[1:0] < BASE_ADDR[1:0]);

    assign wait_done = (wait_cnt == LAST_CNT);
    assign in_access = (state == RD_LO) || (state == RD_HI) ||
                       (state == WR_LO) || (state == WR_HI);

    // The pass-through signals ignore the FSM completely.
    assign wb_en    = wb_en_in;
    assign mem_r_en = mem_r_en_in;
    assign alu_res  = alu_res_in;
    assign dest     = dest_in;

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase wait counter: restarts at zero whenever a state is entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state_next != state) begin
            wait_cnt <= '0;
        end else if (in_access) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // Next-state logic and SRAM/handshake outputs. Defaults describe an idle bus.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;

        case (state)
            IDLE: begin
                if (mem_w_en_in) begin
                    state_next = WR_LO;
                end else if (mem_r_en_in) begin
                    state_next = RD_LO;
                end else begin
                    ready = 1'b1;
                end
            end

            RD_LO: begin
                sram_addr = {word_idx, 1'b0};
                if (wait_done) begin
                    state_next = RD_HI;
                end
            end

            RD_HI: begin
                sram_addr = {word_idx, 1'b1};
                if (wait_done) begin
                    state_next = DONE;
                end
            end

            WR_LO: begin
                sram_addr   = {word_idx, 1'b0};
                sram_dq_out = val_rm_in[15:0];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                if (wait_done) begin
                    state_next = WR_HI;
                end
            end

            WR_HI: begin
                sram_addr   = {word_idx, 1'b1};
                sram_dq_out = val_rm_in[31:16];
                sram_dq_oe  = 1'b1;
                sram_we_n   = 1'b0;
                if (wait_done) begin
                    state_next = DONE;
                end
            end

            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Load result register: each half is captured on the last cycle of its
    // read phase and held at all other times, including during writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_data <= '0;
        end else if ((state == RD_LO) && wait_done) begin
            mem_data[15:0] <= sram_dq_in;
        end else if ((state == RD_HI) && wait_done) begin
            mem_data[31:16] <= sram_dq_in;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Testbench for mem_stage_sram. It pairs the DUT with a small SRAM model and
// runs a table of idle vectors, followed by directed load/store sequences.
module tb_mem_stage_sram;

    localparam int W = 2;

    logic        clk;
    logic        rst;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_res_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_in;
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu_res;
    logic [3:0]  dest;
    logic [31:0] mem_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    int checks;
    int errors;

    logic [15:0] sram_model [0:255];

    mem_stage_sram #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (32'd1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en_in    (wb_en_in),
        .mem_r_en_in (mem_r_en_in),
        .mem_w_en_in (mem_w_en_in),
        .alu_res_in  (alu_res_in),
        .val_rm_in   (val_rm_in),
        .dest_in     (dest_in),
        .wb_en       (wb_en),
        .mem_r_en    (mem_r_en),
        .alu_res     (alu_res),
        .dest        (dest),
        .mem_data    (mem_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in),
        .sram_we_n   (sram_we_n)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: preloaded with known words during reset, written on strobe.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) sram_model[i] <= 16'h0000;
            sram_model[0] <= 16'h1234;
            sram_model[1] <= 16'h5678;
            sram_model[4] <= 16'h9ABC;
            sram_model[5] <= 16'hDEF0;
        end else if (!sram_we_n && sram_dq_oe) begin
            sram_model[sram_addr[7:0]] <= sram_dq_out;
        end
    end

    assign sram_dq_in = sram_model[sram_addr[7:0]];

    // Hard time limit so the run always ends on its own.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic        wb;
        logic [31:0] alu;
        logic [31:0] rm;
        logic [3:0]  dst;
        logic        exp_wb;
        logic [31:0] exp_alu;
        logic [3:0]  exp_dest;
        logic        exp_ready;
        logic        exp_we_n;
        logic [17:0] exp_addr;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        wb_en_in    = v.wb;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = v.alu;
        val_rm_in   = v.rm;
        dest_in     = v.dst;
    endtask

    // Runs one complete access and checks every cycle until the DONE cycle.
    // The caller must be just past a negedge, either in IDLE or in DONE.
    task automatic runAccess(input logic do_w, input logic do_r,
                             input logic [31:0] addr, input logic [31:0] data,
                             input logic from_done, input logic [31:0] exp_mem,
                             input string tag);
        logic [16:0] idx;
        logic        hi;
        logic [15:0] exp_dq;
        idx = 17'((addr - 32'd1024) >> 2);
        mem_w_en_in = do_w;
        mem_r_en_in = do_r;
        alu_res_in  = addr;
        val_rm_in   = data;
        wb_en_in    = do_r;
        dest_in     = 4'd3;
        if (from_done) @(negedge clk);
        else #1;
        checkOutput({tag, " idle_ready"}, 32'(ready), 32'd0);
        checkOutput({tag, " mem_r_en_pass"}, 32'(mem_r_en), 32'(do_r));
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            hi = (k >= W);
            exp_dq = do_w ? (hi ? data[31:16] : data[15:0]) : 16'h0000;
            checkOutput({tag, " busy_ready"}, 32'(ready), 32'd0);
            checkOutput({tag, " addr"}, 32'(sram_addr), 32'({idx, hi}));
            checkOutput({tag, " we_n"}, 32'(sram_we_n), 32'(!do_w));
            checkOutput({tag, " oe"}, 32'(sram_dq_oe), 32'(do_w));
            checkOutput({tag, " dq_out"}, 32'(sram_dq_out), 32'(exp_dq));
        end
        @(negedge clk);
        checkOutput({tag, " done_ready"}, 32'(ready), 32'd1);
        checkOutput({tag, " done_addr"}, 32'(sram_addr), 32'd0);
        checkOutput({tag, " done_we_n"}, 32'(sram_we_n), 32'd1);
        checkOutput({tag, " mem_data"}, mem_data, exp_mem);
    endtask

    task automatic goIdle();
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        @(negedge clk);
        checkOutput("back_idle_ready", 32'(ready), 32'd1);
    endtask

    vec_t vecs [4];

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{1'b1, 32'h0000_0055, 32'h0, 4'd7, 1'b1, 32'h0000_0055, 4'd7, 1'b1, 1'b1, 18'd0};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF, 32'h1, 4'd15, 1'b0, 32'hFFFF_FFFF, 4'd15, 1'b1, 1'b1, 18'd0};
        vecs[2] = '{1'b1, 32'h0000_0404, 32'hA5A5_5A5A, 4'd0, 1'b1, 32'h0000_0404, 4'd0, 1'b1, 1'b1, 18'd0};
        vecs[3] = '{1'b0, 32'h8000_0000, 32'h0, 4'd9, 1'b0, 32'h8000_0000, 4'd9, 1'b1, 1'b1, 18'd0};

        rst         = 1'b1;
        wb_en_in    = 1'b0;
        mem_r_en_in = 1'b0;
        mem_w_en_in = 1'b0;
        alu_res_in  = '0;
        val_rm_in   = '0;
        dest_in     = '0;

        // Outputs during reset.
        repeat (2) @(negedge clk);
        checkOutput("rst_mem_data", mem_data, 32'd0);
        checkOutput("rst_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("rst_oe", 32'(sram_dq_oe), 32'd0);
        checkOutput("rst_addr", 32'(sram_addr), 32'd0);
        checkOutput("rst_dq_out", 32'(sram_dq_out), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(ready), 32'd1);

        // Idle vectors: pass-through outputs mirror inputs, and the bus stays quiet.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i]);
            for (int s = 0; s < 2; s++) begin
                if (s == 0) #1;
                else @(negedge clk);
                checkOutput("vec_wb_en", 32'(wb_en), 32'(vecs[i].exp_wb));
                checkOutput("vec_alu_res", alu_res, vecs[i].exp_alu);
                checkOutput("vec_dest", 32'(dest), 32'(vecs[i].exp_dest));
                checkOutput("vec_ready", 32'(ready), 32'(vecs[i].exp_ready));
                checkOutput("vec_we_n", 32'(sram_we_n), 32'(vecs[i].exp_we_n));
                checkOutput("vec_addr", 32'(sram_addr), 32'(vecs[i].exp_addr));
            end
        end

        // Store, then load it back.
        runAccess(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0, 32'd0, "store");
        goIdle();
        runAccess(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0, 32'hDEAD_BEEF, "load");
        goIdle();

        // Both enables asserted: write wins, and mem_data is untouched.
        runAccess(1'b1, 1'b1, 32'd1036, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF, "both");
        goIdle();
        runAccess(1'b0, 1'b1, 32'd1036, 32'h0, 1'b0, 32'hCAFE_F00D, "load_both");
        goIdle();

        // Back-to-back loads. The request stays high through DONE.
        runAccess(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0, 32'h5678_1234, "b2b_a");
        runAccess(1'b0, 1'b1, 32'd1032, 32'h0, 1'b1, 32'hDEF0_9ABC, "b2b_b");
        goIdle();

        // Reset in the second cycle of RD_HI.
        mem_r_en_in = 1'b1;
        alu_res_in  = 32'd1024;
        repeat (3) @(negedge clk);
        checkOutput("abort_lo_captured", mem_data, 32'hDEF0_1234);
        @(negedge clk);
        checkOutput("abort_in_rd_hi_addr", 32'(sram_addr), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("abort_mem_data", mem_data, 32'd0);
        checkOutput("abort_we_n", 32'(sram_we_n), 32'd1);
        checkOutput("abort_addr", 32'(sram_addr), 32'd0);
        checkOutput("abort_oe", 32'(sram_dq_oe), 32'd0);
        mem_r_en_in = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("abort_release_ready", 32'(ready), 32'd1);
        checkOutput("abort_release_mem_data", mem_data, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
